// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial add/subtract unit with valid/ready handshakes.
// Each operation runs through one DIGIT-wide adder slice, least significant
// digit first, taking WIDTH/DIGIT cycles in BUSY. Subtraction is A + ~B + 1.
// Optional feature macro: ADDSUB_SERIAL_SAT_EN. When defined, a signed
// overflow saturates o_c to the most positive or most negative value.
// When undefined, o_c wraps modulo 2^WIDTH.
module addsub_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_c,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  // Reject illegal parameter combinations at elaboration time.
  if (WIDTH < 2) begin : g_bad_width
    $error("addsub_serial: WIDTH must be at least 2");
  end
  if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("addsub_serial: WIDTH must be a non-zero multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Operand, partial result and slice carry registers.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q, cy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Registered result and flags, held outside DONE.
  logic [WIDTH-1:0] c_q, c_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Adder slice signals.
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   slice;
  logic [DIGIT-1:0] sum_dig;
  logic             slice_cout;
  logic             cin_msb;
  logic             ovf_now;
  logic             last_dig;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] final_c;

  // Adder slice, result shift and flag derivation for the current digit.
  // Operands are shifted right each cycle, so the low digit of a_q/b_q is
  // always digit[counter] of the latched operands.
  always_comb begin
    a_dig      = a_q[DIGIT-1:0];
    b_dig      = b_q[DIGIT-1:0];
    slice      = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT+1)'(cy_q);
    sum_dig    = slice[DIGIT-1:0];
    slice_cout = slice[DIGIT];
    last_dig   = (cnt_q == CNT_W'(N - 1));
    res_shift  = (res_q >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
    // Carry into the MSB recovered from the MSB sum bit and its operand bits.
    cin_msb    = sum_dig[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
    ovf_now    = cin_msb ^ slice_cout;
`ifdef ADDSUB_SERIAL_SAT_EN
    if (ovf_now) begin
      final_c = slice_cout ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      final_c = res_shift;
    end
`else
    final_c = res_shift;
`endif
  end

  // Next-state logic for the IDLE / BUSY / DONE sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_valid)  state_d = S_BUSY;
      S_BUSY:  if (last_dig) state_d = S_DONE;
      S_DONE:  if (i_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch on accept, step one digit per BUSY cycle,
  // capture result and flags on the final digit.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d   = i_a;
          b_d   = i_op ? ~i_b : i_b;
          cy_d  = i_op;
          cnt_d = '0;
        end
      end
      S_BUSY: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        res_d = res_shift;
        cy_d  = slice_cout;
        if (last_dig) begin
          cnt_d   = '0;
          c_d     = final_c;
          carry_d = slice_cout;
          ovf_d   = ovf_now;
          zero_d  = (final_c == '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Handshake outputs are pure state decodes; result outputs come from registers.
  always_comb begin
    o_ready = (state_q == S_IDLE);
    o_valid = (state_q == S_DONE);
    o_c     = c_q;
    o_carry = carry_q;
    o_ovf   = ovf_q;
    o_zero  = zero_q;
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers; reset discards any in-flight operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: an 8/2 instance for directed and
// random operations with backpressure, and a 16/16 instance for single-cycle
// random operations. Expected values come from a signed/unsigned arithmetic
// reference model. Honors ADDSUB_SERIAL_SAT_EN in the model.
module tb_addsub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 8-bit, 2-bit digit instance
  logic       v8, op8, r8;
  logic [7:0] a8, b8;
  logic       rdy8, ov8, car8, ovf8, z8;
  logic [7:0] c8;

  // 16-bit, single-digit instance
  logic        v16, op16, r16;
  logic [15:0] a16, b16;
  logic        rdy16, ov16, car16, ovf16, z16;
  logic [15:0] c16;

  addsub_serial #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8), .i_op(op8),
    .i_a(a8), .i_b(b8), .o_valid(ov8), .i_ready(r8), .o_c(c8),
    .o_carry(car8), .o_ovf(ovf8), .o_zero(z8)
  );

  addsub_serial #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(rdy16), .i_op(op16),
    .i_a(a16), .i_b(b16), .o_valid(ov16), .i_ready(r16), .o_c(c16),
    .o_carry(car16), .o_ovf(ovf16), .o_zero(z16)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] c;
    logic        carry;
    logic        ovf;
    logic        zero;
  } res_t;

  // Reference: true signed result, unsigned carry/borrow rule, wrap or saturate.
  function automatic res_t ref_model(input int w, input bit op, input longint a, input longint b);
    res_t   r;
    longint m    = longint'(1) << w;
    longint mask = m - 1;
    longint hi   = (m >> 1) - 1;
    longint lo   = -(m >> 1);
    longint sa   = (a > hi) ? a - m : a;
    longint sb   = (b > hi) ? b - m : b;
    longint tru  = op ? sa - sb : sa + sb;
    longint c;
    r       = '0;
    r.carry = op ? (a >= b) : ((a + b) >= m);
    r.ovf   = (tru > hi) || (tru < lo);
    c       = (op ? a - b : a + b) & mask;
`ifdef ADDSUB_SERIAL_SAT_EN
    if (r.ovf) c = (tru > 0) ? hi : (lo & mask);
`endif
    r.c    = 32'(c);
    r.zero = (c == 0);
    return r;
  endfunction

  // One operation on the 8-bit unit; starts and ends just after a negedge in IDLE.
  task automatic run8(input bit op, input logic [7:0] a, input logic [7:0] b,
                      input int hold, input bit pulse);
    res_t e;
    int   lat;
    e = ref_model(8, op, longint'(a), longint'(b));
    check("rdy8_idle", 32'(rdy8), 32'd1);
    v8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge clk); @(negedge clk);
    v8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); op8 = 1'($urandom);
    r8 = 1'($urandom);
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
      a8 = 8'($urandom); b8 = 8'($urandom); op8 = 1'($urandom);
    end
    check("lat8", 32'(lat), 32'd4);
    check("c8", 32'(c8), e.c);
    check("carry8", 32'(car8), 32'(e.carry));
    check("ovf8", 32'(ovf8), 32'(e.ovf));
    check("zero8", 32'(z8), 32'(e.zero));
    check("rdy8_done", 32'(rdy8), 32'd0);
    r8 = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        v8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 1'($urandom);
      end
      @(posedge clk); @(negedge clk);
      check("hold_valid8", 32'(ov8), 32'd1);
      check("hold_c8", 32'(c8), e.c);
      check("hold_rdy8", 32'(rdy8), 32'd0);
    end
    v8 = 1'b0;
    r8 = 1'b1;
    @(posedge clk); @(negedge clk);
    r8 = 1'b0;
    check("rel_rdy8", 32'(rdy8), 32'd1);
    check("rel_valid8", 32'(ov8), 32'd0);
    check("idle_c8", 32'(c8), e.c);
  endtask

  // One operation on the 16-bit single-digit unit with random consumer stalls.
  task automatic run16(input bit op, input logic [15:0] a, input logic [15:0] b);
    res_t e;
    int   lat;
    int   hold;
    e = ref_model(16, op, longint'(a), longint'(b));
    check("rdy16_idle", 32'(rdy16), 32'd1);
    v16 = 1'b1; op16 = op; a16 = a; b16 = b;
    @(posedge clk); @(negedge clk);
    v16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("lat16", 32'(lat), 32'd1);
    check("c16", 32'(c16), e.c);
    check("carry16", 32'(car16), 32'(e.carry));
    check("ovf16", 32'(ovf16), 32'(e.ovf));
    check("zero16", 32'(z16), 32'(e.zero));
    hold = int'($urandom_range(0, 3));
    r16 = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid16", 32'(ov16), 32'd1);
    end
    r16 = 1'b1;
    @(posedge clk); @(negedge clk);
    r16 = 1'b0;
    check("rel_rdy16", 32'(rdy16), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    v8 = 1'b0; op8 = 1'b0; r8 = 1'b0; a8 = '0; b8 = '0;
    v16 = 1'b0; op16 = 1'b0; r16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy8", 32'(rdy8), 32'd1);
    check("rst_valid8", 32'(ov8), 32'd0);
    check("rst_c8", 32'(c8), 32'd0);
    check("rst_flags8", 32'({car8, ovf8, z8}), 32'd0);
    check("rst_rdy16", 32'(rdy16), 32'd1);
    check("rst_valid16", 32'(ov16), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases on the 8-bit unit
    run8(1'b0, 8'h12, 8'h34, 0, 1'b0);
    check("dir_46", 32'(c8), 32'h46);
    run8(1'b1, 8'h05, 8'h05, 0, 1'b0);
    check("dir_zero", 32'(z8), 32'd1);
    run8(1'b1, 8'h03, 8'h05, 0, 1'b0);
    check("dir_fe", 32'(c8), 32'hFE);
    run8(1'b0, 8'h7F, 8'h01, 0, 1'b0);
    check("dir_ovf_add", 32'(ovf8), 32'd1);
    run8(1'b1, 8'h80, 8'h01, 0, 1'b0);
    check("dir_ovf_sub", 32'(ovf8), 32'd1);
    run8(1'b0, 8'h21, 8'h43, 5, 1'b1);

    // Reset during the second BUSY cycle discards the operation
    v8 = 1'b1; op8 = 1'b0; a8 = 8'h55; b8 = 8'h22;
    @(posedge clk); @(negedge clk);
    v8 = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("mid_rst_rdy8", 32'(rdy8), 32'd1);
    check("mid_rst_valid8", 32'(ov8), 32'd0);
    check("mid_rst_c8", 32'(c8), 32'd0);
    check("mid_rst_flags8", 32'({car8, ovf8, z8}), 32'd0);
    run8(1'b0, 8'hFF, 8'h01, 0, 1'b0);
    check("dir_ff_01", 32'({c8, car8, z8}), 32'({8'h00, 1'b1, 1'b1}));

    // Random 8-bit operations with backpressure and ignored i_valid pulses
    for (int i = 0; i < 200; i++) begin
      run8(1'($urandom), 8'($urandom), 8'($urandom),
           int'($urandom_range(0, 2)), 1'($urandom));
    end

    // 16-bit single-digit unit
    run16(1'b0, 16'hFFFF, 16'h0001);
    check("dir16_wrap", 32'({c16, car16}), 32'({16'h0000, 1'b1}));
    for (int i = 0; i < 1000; i++) begin
      run16(1'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
